pipe_valid_adapter: RTL and testbench

PIPE_VALID_ADAPTER -- requirements
Module: pipe_valid_adapter

---
 rtl/pipe_valid_adapter.sv | 132 +++++++++++++
 tb/tb_pipe_valid_adapter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_valid_adapter.sv
// Credit-based valid/ready wrapper around a non-stallable fixed-latency pipeline; requests issue with zero added latency, results surface one cycle after pipe_output_valid.
// in_ready throttles issue so pipeline occupancy plus queued results never exceeds DEPTH; PIPE_VALID_ADAPTER_ERR_CHECK_EN enables the sticky err flag.
module pipe_valid_adapter #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             pipe_input_valid,
  output logic [WIDTH-1:0] pipe_x,
  input  logic [WIDTH-1:0] pipe_out,
  input  logic             pipe_output_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_SUM  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pipe_valid_adapter: DEPTH must be a power of two and at least 2");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $error("pipe_valid_adapter: LATENCY must be at least 1");
    end
  endgenerate

  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic accept;
  logic pop;
  logic push;
  logic retire;
  logic spurious;
  logic overflow;

  // Credit check uses registered state only, so a pop frees a slot one cycle later.
  assign in_ready = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_SUM;

  // rst gates issue so nothing enters the pipeline while its valid chain is held clear.
  assign accept           = in_valid & in_ready & rst;
  assign pipe_input_valid = accept;
  assign pipe_x           = in_data;

  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr_q];
  assign pop       = out_valid & out_ready;

  // A result with nothing outstanding, or one arriving into a full queue that is not
  // draining this cycle, cannot be stored without corrupting order, so it is dropped.
  assign spurious = pipe_output_valid & (inflight_q == '0);
  assign overflow = pipe_output_valid & (count_q == DEPTH_FULL) & ~pop;
  assign retire   = pipe_output_valid & ~spurious;
  assign push     = retire & ~overflow;

  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept && !retire) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!accept && retire) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is intentionally left out of reset; count_q guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= pipe_out;
    end
  end

`ifdef PIPE_VALID_ADAPTER_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (spurious || overflow) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_valid_adapter.sv
// Directed self-checking bench for pipe_valid_adapter driving a LATENCY=3, f(x)=x+3 pipeline model.
module tb_pipe_valid_adapter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             pipe_input_valid;
  logic [WIDTH-1:0] pipe_x;
  logic [WIDTH-1:0] pipe_out;
  logic             pipe_output_valid;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             err;

  logic [2:0]       mv;
  logic [WIDTH-1:0] md [3];
  logic             spur;
  logic [WIDTH-1:0] spur_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_valid_adapter #(.WIDTH(WIDTH), .DEPTH(4), .LATENCY(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_x            (pipe_x),
    .pipe_out          (pipe_out),
    .pipe_output_valid (pipe_output_valid),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .err               (err)
  );

  // Pipeline model: three-stage valid chain cleared by the same reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= 3'b000;
    end else begin
      mv    <= {mv[1:0], pipe_input_valid};
      md[0] <= pipe_x + 32'd3;
      md[1] <= md[0];
      md[2] <= md[1];
    end
  end

  assign pipe_output_valid = mv[2] | spur;
  assign pipe_out          = spur ? spur_dat : md[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; spur = 1'b0; spur_dat = '0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (pipe_input_valid !== 1'b0) begin errors++; $display("FAIL reset_pipe_input_valid: got %b expected 0", pipe_input_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || pipe_input_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_first_cycle: in_ready=%b out_valid=%b piv=%b expected 1 0 0", in_ready, out_valid, pipe_input_valid);
    end
  endtask

  task automatic test_single;
    tick;
    in_valid = 1'b1; in_data = 32'h10;
    #1;
    checks++; if (pipe_input_valid !== 1'b1 || pipe_x !== 32'h10) begin
      errors++; $display("FAIL single_issue: piv=%b x=%h expected 1 00000010", pipe_input_valid, pipe_x);
    end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (pipe_input_valid !== 1'b0) begin errors++; $display("FAIL single_issue_once: got %b expected 0", pipe_input_valid); end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_out c%0d: got %b expected 0", c, out_valid); end
    end
    tick;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h13) begin
      errors++; $display("FAIL single_result: valid=%b data=%h expected 1 00000013", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b expected 0", out_valid); end
  endtask

  task automatic test_credit_limit;
    int acc;
    logic took;
    acc = 0; took = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (took) in_data = in_data + 32'd1;
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== (c < 4)) begin errors++; $display("FAIL credit_in_ready c%0d: got %b expected %b", c, in_ready, (c < 4)); end
      took = in_ready;
      if (took) acc++;
    end
    in_valid = 1'b0;
    checks++; if (acc !== 4) begin errors++; $display("FAIL credit_accepts: got %0d expected 4", acc); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin
      errors++; $display("FAIL credit_head: valid=%b data=%h expected 1 00000003", out_valid, out_data);
    end
    checks++; if (err !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL credit_full_state: err=%b in_ready=%b expected 0 0", err, in_ready);
    end
  endtask

  task automatic test_push_pop_full;
    logic [WIDTH-1:0] exp_q [3];
    exp_q = '{32'h5, 32'h6, 32'h23};
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_credit_not_comb: got %b expected 0", in_ready); end
    tick;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_credit_next_cycle: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_data = 32'h20;
    #1;
    checks++; if (pipe_input_valid !== 1'b1) begin errors++; $display("FAIL pp_refill_issue: got %b expected 1", pipe_input_valid); end
    tick;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_full_again: got %b expected 0", in_ready); end
    tick;
    tick;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h4) begin
      errors++; $display("FAIL pp_pop_head: valid=%b data=%h expected 1 00000004", out_valid, out_data);
    end
    tick;
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_in_ready_after_swap: got %b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
        errors++; $display("FAIL pp_order[%0d]: valid=%b data=%h expected 1 %h", i, out_valid, out_data, exp_q[i]);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int nxt;
    int got;
    logic took;
    nxt = 0; got = 0; took = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 300 && got < 20; c++) begin
      tick;
      if (took) nxt++;
      in_valid = (nxt < 20);
      in_data  = nxt;
      #1;
      if (out_valid) begin
        checks++; if (out_data !== got + 3) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", got, out_data, got + 3);
        end
        got++;
      end
      took = in_valid & in_ready;
    end
    in_valid = 1'b0;
    checks++; if (got !== 20) begin errors++; $display("FAIL b2b_count: got %0d results expected 20", got); end
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    logic stale;
    tick;
    in_valid = 1'b1; in_data = 32'h40;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    in_valid = 1'b1; in_data = 32'h41;
    tick;
    in_data = 32'h42;
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h43) begin
      errors++; $display("FAIL rm_prereset: valid=%b data=%h expected 1 00000043", out_valid, out_data);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pipe_input_valid !== 1'b0) begin
      errors++; $display("FAIL rm_in_reset: out_valid=%b in_ready=%b piv=%b expected 0 1 0", out_valid, in_ready, pipe_input_valid);
    end
    tick; tick;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rm_stale_result: saw out_valid=1 expected none"); end
    checks++; if (in_ready !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL rm_after_release: in_ready=%b err=%b expected 1 0", in_ready, err);
    end
  endtask

  task automatic test_err;
    logic exp_err;
`ifdef PIPE_VALID_ADAPTER_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tick;
    spur = 1'b1; spur_dat = 32'hdead;
    tick;
    spur = 1'b0;
    #1;
    checks++; if (err !== exp_err) begin errors++; $display("FAIL err_spurious: got %b expected %b", err, exp_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_write_dropped: out_valid=%b expected 0", out_valid); end
    tick; tick; tick;
    checks++; if (err !== exp_err) begin errors++; $display("FAIL err_sticky: got %b expected %b", err, exp_err); end
    rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset_clear: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset;
    test_single;
    test_credit_limit;
    test_push_pop_full;
    test_back_to_back;
    test_reset_mid;
    test_err;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
